// File: rtl/piso_frame_tx.sv
`default_nettype none
// ============================================================================
// Module  : piso_frame_tx
// Brief   : MSB-first word serializer paced by ser_en, with a post-frame gap
// Revision: 1.0 - initial release
// ============================================================================
module piso_frame_tx #(
   parameter int BITS = 4,
   parameter int GAP  = 1
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [BITS-1:0] in_data,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            ser_en,
   output logic            ser_out,
   output logic            ser_valid,
   output logic            frame_start,
   output logic            frame_done,
   output logic            busy
);

   localparam int CNT_W = $clog2(BITS);
   localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BITS - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_GAP   = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [BITS-1:0]  sreg_q, sreg_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
   logic             ser_out_q, ser_out_d;
   logic             ser_valid_q, ser_valid_d;
   logic             frame_start_q, frame_start_d;
   logic             frame_done_q, frame_done_d;
   logic             busy_q, busy_d;

   assign in_ready = (state_q == S_IDLE) && !RST;

   always_comb begin
      state_d      = state_q;
      sreg_d       = sreg_q;
      bit_cnt_d    = bit_cnt_q;
      gap_cnt_d    = gap_cnt_q;
      frame_done_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready) begin
               sreg_d    = in_data;
               bit_cnt_d = '0;
               state_d   = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (ser_en) begin
               sreg_d = {sreg_q[BITS-2:0], 1'b0};
               // bit_cnt parks at BITS-1 on the last bit rather than wrapping
               if (bit_cnt_q == BIT_LAST) begin
                  frame_done_d = 1'b1;
                  gap_cnt_d    = '0;
                  state_d      = (GAP > 0) ? S_GAP : S_IDLE;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         S_GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               state_d = S_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are registered from the next-state view so they line up with state_q
      ser_valid_d   = (state_d == S_SHIFT);
      ser_out_d     = ser_valid_d && sreg_d[BITS-1];
      frame_start_d = ser_valid_d && (bit_cnt_d == '0);
      busy_d        = (state_d != S_IDLE);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q       <= S_IDLE;
         sreg_q        <= '0;
         bit_cnt_q     <= '0;
         gap_cnt_q     <= '0;
         ser_out_q     <= 1'b0;
         ser_valid_q   <= 1'b0;
         frame_start_q <= 1'b0;
         frame_done_q  <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         sreg_q        <= sreg_d;
         bit_cnt_q     <= bit_cnt_d;
         gap_cnt_q     <= gap_cnt_d;
         ser_out_q     <= ser_out_d;
         ser_valid_q   <= ser_valid_d;
         frame_start_q <= frame_start_d;
         frame_done_q  <= frame_done_d;
         busy_q        <= busy_d;
      end
   end

   assign ser_out     = ser_out_q;
   assign ser_valid   = ser_valid_q;
   assign frame_start = frame_start_q;
   assign frame_done  = frame_done_q;
   assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_piso_frame_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_piso_frame_tx
// Brief   : three piso_frame_tx configurations against a strobe-counting frame model
// Revision: 1.0 - initial release
// ============================================================================
module tb_piso_frame_tx;

   logic CLK = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // cfg0: BITS=4 GAP=2, cfg1: BITS=4 GAP=0, cfg2: BITS=8 GAP=1
   for (genvar g = 0; g < 3; g++) begin : g_cfg
      localparam int B = (g == 2) ? 8 : 4;
      localparam int G = (g == 0) ? 2 : ((g == 1) ? 0 : 1);

      logic         rst, in_valid, in_ready, ser_en;
      logic         ser_out, ser_valid, frame_start, frame_done, busy;
      logic [B-1:0] in_data;
      logic         done = 1'b0;

      piso_frame_tx #(.BITS(B), .GAP(G)) u_dut (
         .CLK         (CLK),
         .RST         (rst),
         .in_data     (in_data),
         .in_valid    (in_valid),
         .in_ready    (in_ready),
         .ser_en      (ser_en),
         .ser_out     (ser_out),
         .ser_valid   (ser_valid),
         .frame_start (frame_start),
         .frame_done  (frame_done),
         .busy        (busy)
      );

      task automatic tick();
         @(posedge CLK);
         #1;
      endtask

      // exp packs {ser_out, ser_valid, frame_start, frame_done, busy, in_ready}
      task automatic expect_outs(input string what, input int k, input logic [5:0] exp);
         logic [5:0] got;
         got = {ser_out, ser_valid, frame_start, frame_done, busy, in_ready};
         check($sformatf("cfg%0d %s k=%0d {out,valid,start,done,busy,ready}", g, what, k),
               {26'd0, got}, {26'd0, exp});
      endtask

      task automatic accept(input logic [7:0] word);
         int waited;
         waited   = 0;
         in_valid = 1'b1;
         in_data  = word[B-1:0];
         ser_en   = 1'b1;
         while (in_ready !== 1'b1 && waited < 100) begin
            tick();
            waited++;
         end
         check($sformatf("cfg%0d accept wait", g), {31'd0, (waited < 100)}, 32'd1);
         tick();
         in_valid = 1'b0;
         in_data  = B'($urandom);
      endtask

      // Model: the bit on the line is the one indexed by the number of ser_en
      // strobes seen since the accept; the gap is counted in plain cycles.
      task automatic frame(input logic [7:0] word, input int period, input bit hold,
                           input logic [7:0] next_word);
         int           nb;
         int           t;
         int           k;
         logic         consumed;
         logic [5:0]   exp;
         logic [B-1:0] w;
         nb = 0;
         t  = -1;
         k  = 1;
         w  = word[B-1:0];
         forever begin
            if (nb < B) exp = {w[B-1-nb], 1'b1, (nb == 0), 1'b0, 1'b1, 1'b0};
            else        exp = {1'b0, 1'b0, 1'b0, (t == 0), (t < G), (t >= G)};
            expect_outs("frame", k, exp);
            if (nb >= B && t >= G) break;
            if (k >= 400) begin
               check($sformatf("cfg%0d frame cycle budget", g), 32'd0, 32'd1);
               break;
            end
            if (nb < B)
               ser_en = (period == 0) ? 1'($urandom_range(0, 1)) : ((k % period) == 0);
            else
               ser_en = 1'($urandom_range(0, 1));
            in_valid = hold;
            in_data  = hold ? next_word[B-1:0] : B'($urandom);
            consumed = (nb < B) && ser_en;
            tick();
            if (t >= 0) t++;
            else if (consumed) begin
               nb++;
               if (nb == B) t = 0;
            end
            k++;
         end
      endtask

      task automatic reset_mid();
         logic [B-1:0] w;
         w = 8'hCC;
         accept(8'hCC);
         ser_en = 1'b1;
         tick();
         tick();
         expect_outs("pre-reset", 3, {w[B-3], 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
         #1 rst = 1'b1;
         #1 expect_outs("async reset", 0, 6'b000000);
         for (int i = 0; i < 3; i++) begin
            ser_en = 1'($urandom_range(0, 1));
            tick();
            expect_outs("in reset", i, 6'b000000);
         end
         rst = 1'b0;
         #1 expect_outs("after reset", 0, 6'b000001);
         accept(8'h66);
         frame(8'h66, 1, 1'b0, 8'h00);
      endtask

      initial begin
         logic [7:0] cur, nxt;
         rst      = 1'b1;
         in_valid = 1'b0;
         in_data  = '0;
         ser_en   = 1'b0;
         tick();
         expect_outs("reset", 0, 6'b000000);
         in_valid = 1'b1;
         ser_en   = 1'b1;
         tick();
         expect_outs("reset valid", 0, 6'b000000);
         in_valid = 1'b0;
         rst      = 1'b0;
         #1 expect_outs("idle", 0, 6'b000001);

         accept(8'h0B); frame(8'h0B, 1, 1'b0, 8'h00);
         accept(8'h08); frame(8'h08, 3, 1'b0, 8'h00);
         accept(8'h81); frame(8'h81, 1, 1'b0, 8'h00);
         accept(8'h0A); frame(8'h0A, 1, 1'b1, 8'h05);
         accept(8'h05); frame(8'h05, 1, 1'b0, 8'h00);
         accept(8'h0F); frame(8'h0F, 1, 1'b1, 8'h00);
         accept(8'h00); frame(8'h00, 2, 1'b0, 8'h00);
         reset_mid();

         cur = 8'($urandom);
         for (int i = 0; i < 20; i++) begin
            nxt = 8'($urandom);
            accept(cur);
            frame(cur, $urandom_range(0, 3), 1'($urandom_range(0, 1)), nxt);
            cur = nxt;
         end
         done = 1'b1;
      end
   end

   initial begin : p_main
      int cyc;
      cyc = 0;
      while (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done) && cyc < 60000) begin
         @(posedge CLK);
         cyc++;
      end
      check("all configs finished",
            {29'd0, g_cfg[2].done, g_cfg[1].done, g_cfg[0].done}, 32'd7);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
